// File: rtl/bht_pkg.sv
// rtl/bht_pkg.sv - shared types, defaults and counter helper for the branch history table
package bht_pkg;

    localparam int IDX_W_DEF = 5;
    localparam int CTR_W_DEF = 2;
    localparam int MAX_CTR_W = 8;

    typedef logic [0:0] state_t;
    localparam state_t ST_INIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // Saturating step of a counter held zero-extended in MAX_CTR_W bits; ctr_max is all-ones for the real width.
    function automatic logic [MAX_CTR_W-1:0] sat_update(
        input logic [MAX_CTR_W-1:0] ctr,
        input logic [MAX_CTR_W-1:0] ctr_max,
        input logic                 taken
    );
        if (taken) begin
            return (ctr == ctr_max) ? ctr : ctr + 8'd1;
        end
        return (ctr == '0) ? ctr : ctr - 8'd1;
    endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// rtl/bht_predictor_if.sv - fetch-side prediction and EX-side training signals
interface bht_predictor_if
    import bht_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
);
    logic [IDX_W-1:0] pred_pc;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             ready;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;

    modport master (
        output pred_pc, upd_valid, upd_idx, upd_taken,
        input  pred_taken, pred_idx, ready
    );

    modport slave (
        input  pred_pc, upd_valid, upd_idx, upd_taken,
        output pred_taken, pred_idx, ready
    );
endinterface

// File: rtl/bht_sat_ctr_array.sv
// rtl/bht_sat_ctr_array.sv - counter storage with one write port and two combinational read ports
module bht_sat_ctr_array #(
    parameter int IDX_W = 5,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [CTR_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic [IDX_W-1:0] mod_idx,
    output logic [CTR_W-1:0] mod_data
);
    // Not reset: the init sweep in the parent clears every entry.
    logic [CTR_W-1:0] mem [1 << IDX_W];

    // Single synchronous write: init sweep or training update.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_taken = mem[rd_idx][CTR_W-1];
    assign mod_data = mem[mod_idx];

endmodule

// File: rtl/bht_predictor.sv
// rtl/bht_predictor.sv - parametrised branch predictor; optional gshare hash under BHT_PREDICTOR_GSHARE_EN
module bht_predictor
    import bht_pkg::*;
#(
    parameter int             IDX_W    = IDX_W_DEF,
    parameter int             CTR_W    = CTR_W_DEF,
    parameter int             GHR_W    = 5,
    parameter logic [CTR_W-1:0] INIT_CTR = CTR_W'((1 << (CTR_W - 1)) - 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    bht_predictor_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = '1;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    state_t           state;
    logic [IDX_W-1:0] init_ptr;
    logic [GHR_W-1:0] hist;
    logic             run;
    logic             pred_bit;
    logic [CTR_W-1:0] upd_ctr;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [CTR_W-1:0] wr_data;

    assign run = (state == ST_RUN);

    // Init sweep: one entry per clock, then move to RUN on the last write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_ptr <= '0;
        end else if (state == ST_INIT) begin
            init_ptr <= init_ptr + 1'b1;
            if (init_ptr == LAST_IDX) begin
                state <= ST_RUN;
            end
        end
    end

`ifdef BHT_PREDICTOR_GSHARE_EN
    // Non-speculative history: shifted only when a resolved branch trains the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (run && bus.upd_valid) begin
            hist <= GHR_W'({hist, bus.upd_taken});
        end
    end
`else
    localparam logic [GHR_W-1:0] NO_HIST = '0;
    assign hist = NO_HIST;
`endif

    assign bus.pred_idx = bus.pred_pc ^ IDX_W'(hist);

    // Write port select: sweep entries during INIT, saturating training in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = init_ptr;
        wr_data = INIT_CTR;
        if (!run) begin
            wr_en = 1'b1;
        end else if (bus.upd_valid) begin
            wr_en   = 1'b1;
            wr_idx  = bus.upd_idx;
            wr_data = CTR_W'(sat_update(MAX_CTR_W'(upd_ctr), MAX_CTR_W'(CTR_MAX), bus.upd_taken));
        end
    end

    bht_sat_ctr_array #(
        .IDX_W (IDX_W),
        .CTR_W (CTR_W)
    ) u_array (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .rd_idx   (bus.pred_idx),
        .rd_taken (pred_bit),
        .mod_idx  (bus.upd_idx),
        .mod_data (upd_ctr)
    );

    assign bus.ready      = run;
    assign bus.pred_taken = run & pred_bit;

endmodule

// File: tb/tb_bht_predictor.sv
// tb/tb_bht_predictor.sv - randomized self-checking bench for bht_predictor against a counter model
module tb_bht_predictor;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   mctr [32];
    int   mghr;

    bht_predictor_if #(.IDX_W(5)) bus ();

    bht_predictor #(.IDX_W(5), .CTR_W(2), .GHR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Table index the predictor should use for a given PC (or PC for a given index: XOR is its own inverse).
    function automatic int hash(input int x);
`ifdef BHT_PREDICTOR_GSHARE_EN
        return (x ^ mghr) & 31;
`else
        return x & 31;
`endif
    endfunction

    function automatic void model_init();
        for (int i = 0; i < 32; i++) mctr[i] = 1;
        mghr = 0;
    endfunction

    function automatic void model_update(input int idx, input int t);
        if (t != 0) mctr[idx] = (mctr[idx] < 3) ? mctr[idx] + 1 : 3;
        else        mctr[idx] = (mctr[idx] > 0) ? mctr[idx] - 1 : 0;
        mghr = ((mghr << 1) | (t & 1)) & 31;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        bus.upd_valid = 1'b0;
        bus.upd_idx   = '0;
        bus.upd_taken = 1'b0;
        bus.pred_pc   = 5'd0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        step();
        checks++;
        if (bus.ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
        checks++;
        if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", bus.pred_taken); end
        rst_n = 1'b1;
        wait_ready(n);
        checks++;
        if (n != 32) begin failures++; $display("FAIL reset_init_cycles got=%0d exp=32", n); end
        model_init();
        for (int i = 0; i < 32; i++) begin
            bus.pred_pc = 5'(hash(i));
            #1;
            checks++;
            if (bus.pred_taken !== 1'b0 || bus.pred_idx !== 5'(i)) begin
                failures++;
                $display("FAIL reset_entry idx=%0d got_idx=%0d got_taken=%b exp_taken=0", i, bus.pred_idx, bus.pred_taken);
            end
            step();
        end
    endtask

    task automatic test_history();
        int hist_t [3] = '{1, 1, 0};
        for (int k = 0; k < 3; k++) begin
            bus.upd_valid = 1'b1;
            bus.upd_idx   = 5'd0;
            bus.upd_taken = hist_t[k][0];
            step();
            model_update(0, hist_t[k]);
        end
        bus.upd_valid = 1'b0;
        bus.pred_pc   = 5'b00001;
        #1;
        checks++;
`ifdef BHT_PREDICTOR_GSHARE_EN
        if (bus.pred_idx !== 5'b00111) begin failures++; $display("FAIL history_idx got=%b exp=00111", bus.pred_idx); end
`else
        if (bus.pred_idx !== 5'b00001) begin failures++; $display("FAIL history_idx got=%b exp=00001", bus.pred_idx); end
`endif
        checks++;
        if (bus.pred_taken !== (mctr[hash(1)] >= 2)) begin
            failures++;
            $display("FAIL history_pred got=%b exp=%0d", bus.pred_taken, mctr[hash(1)] >= 2);
        end
    endtask

    task automatic test_sat_taken();
        logic exp_pred [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        step();
        for (int k = 0; k < 4; k++) begin
            bus.upd_valid = 1'b1;
            bus.upd_idx   = 5'd7;
            bus.upd_taken = 1'b1;
            step();
            model_update(7, 1);
            bus.upd_valid = 1'b0;
            bus.pred_pc   = 5'(hash(7));
            #1;
            checks++;
            if (bus.pred_taken !== exp_pred[k] || (mctr[7] >= 2) != exp_pred[k]) begin
                failures++;
                $display("FAIL sat_taken step=%0d got=%b exp=%b", k, bus.pred_taken, exp_pred[k]);
            end
            bus.pred_pc = 5'(hash(6));
            #1;
            checks++;
            if (bus.pred_taken !== (mctr[6] >= 2)) begin
                failures++;
                $display("FAIL sat_taken_neighbour step=%0d got=%b exp=%0d", k, bus.pred_taken, mctr[6] >= 2);
            end
        end
    endtask

    task automatic test_sat_not_taken();
        logic exp_pred [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            step();
            bus.upd_valid = 1'b1;
            bus.upd_idx   = 5'd7;
            bus.upd_taken = 1'b0;
            step();
            model_update(7, 0);
            bus.upd_valid = 1'b0;
            bus.pred_pc   = 5'(hash(7));
            #1;
            checks++;
            if (bus.pred_taken !== exp_pred[k]) begin
                failures++;
                $display("FAIL sat_not_taken step=%0d got=%b exp=%b", k, bus.pred_taken, exp_pred[k]);
            end
        end
    endtask

    task automatic test_collision();
        step();
        bus.pred_pc   = 5'(hash(3));
        bus.upd_valid = 1'b1;
        bus.upd_idx   = 5'd3;
        bus.upd_taken = 1'b1;
        #1;
        checks++;
        if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL collision_same_cycle got=%b exp=0", bus.pred_taken); end
        step();
        model_update(3, 1);
        bus.upd_valid = 1'b0;
        bus.pred_pc   = 5'(hash(3));
        #1;
        checks++;
        if (bus.pred_taken !== 1'b1) begin failures++; $display("FAIL collision_next_cycle got=%b exp=1", bus.pred_taken); end
    endtask

    task automatic test_random();
        int pend_v = 0;
        int pend_i = 0;
        int pend_t = 0;
        int pc;
        for (int k = 0; k < 400; k++) begin
            step();
            if (pend_v != 0) model_update(pend_i, pend_t);
            pend_v = ($urandom_range(0, 2) != 0) ? 1 : 0;
            pend_i = $urandom_range(0, 31);
            pend_t = $urandom_range(0, 1);
            pc     = $urandom_range(0, 31);
            bus.upd_valid = pend_v[0];
            bus.upd_idx   = 5'(pend_i);
            bus.upd_taken = pend_t[0];
            bus.pred_pc   = 5'(pc);
            #1;
            checks++;
            if (bus.pred_idx !== 5'(hash(pc)) || bus.pred_taken !== (mctr[hash(pc)] >= 2)) begin
                failures++;
                $display("FAIL random k=%0d pc=%0d got_idx=%0d exp_idx=%0d got_taken=%b exp_taken=%0d",
                         k, pc, bus.pred_idx, hash(pc), bus.pred_taken, mctr[hash(pc)] >= 2);
            end
        end
        step();
        if (pend_v != 0) model_update(pend_i, pend_t);
        bus.upd_valid = 1'b0;
    endtask

    task automatic verify_init(input string tag);
        for (int i = 0; i < 32; i++) begin
            bus.upd_valid = 1'b0;
            bus.pred_pc   = 5'(hash(i));
            #1;
            checks++;
            if (bus.pred_taken !== 1'b0 || bus.pred_idx !== 5'(i)) begin
                failures++;
                $display("FAIL %s_pre idx=%0d got_idx=%0d got_taken=%b exp_taken=0", tag, i, bus.pred_idx, bus.pred_taken);
            end
            bus.upd_valid = 1'b1;
            bus.upd_idx   = 5'(i);
            bus.upd_taken = 1'b1;
            step();
            model_update(i, 1);
            bus.upd_valid = 1'b0;
            bus.pred_pc   = 5'(hash(i));
            #1;
            checks++;
            if (bus.pred_taken !== 1'b1) begin
                failures++;
                $display("FAIL %s_post idx=%0d got=%b exp=1", tag, i, bus.pred_taken);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin failures++; $display("FAIL mid_init_ready got=%b exp=0", bus.ready); end
        step();
        rst_n = 1'b1;
        wait_ready(n);
        checks++;
        if (n != 32) begin failures++; $display("FAIL mid_init_cycles got=%0d exp=32", n); end
        model_init();
        verify_init("mid_init");
    endtask

    task automatic test_reset_mid_run();
        int n;
        step();
        checks++;
        if (bus.ready !== 1'b1) begin failures++; $display("FAIL mid_run_ready_before got=%b exp=1", bus.ready); end
        bus.upd_valid = 1'b1;
        bus.upd_idx   = 5'd5;
        bus.upd_taken = 1'b1;
        bus.pred_pc   = 5'(hash(5));
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin failures++; $display("FAIL mid_run_ready got=%b exp=0", bus.ready); end
        checks++;
        if (bus.pred_taken !== 1'b0) begin failures++; $display("FAIL mid_run_pred got=%b exp=0", bus.pred_taken); end
        step();
        bus.upd_valid = 1'b0;
        rst_n = 1'b1;
        wait_ready(n);
        checks++;
        if (n != 32) begin failures++; $display("FAIL mid_run_cycles got=%0d exp=32", n); end
        model_init();
        verify_init("mid_run");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_init();
        test_reset();
        test_history();
        test_sat_taken();
        test_sat_not_taken();
        test_collision();
        test_random();
        test_reset_mid_init();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
